// File: rtl/i2c_pkg.sv
// Shared types and register map for the I2C temperature-sensor target.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK
    } state_t;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_ID       = 8'h0B;

    function automatic logic [7:0] reg_read(input logic [7:0]  p,
                                            input logic [15:0] shadow,
                                            input logic [7:0]  id);
        logic [7:0] r;
        case (p)
            REG_TEMP_MSB: r = shadow[15:8];
            REG_TEMP_LSB: r = shadow[7:0];
            REG_ID:       r = id;
            default:      r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the clk domain and flags SCL edges and START/STOP.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_hist_q, scl_hist_d;
    logic       sda_hist_q, sda_hist_d;
    logic       scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
        scl_hist_d = scl_sync_q[1];
        sda_hist_d = sda_sync_q[1];
    end

    // Idle bus reads as both lines high, so everything resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s &  scl_hist_q;
    assign start_det =  scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  =  scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target exposing a temperature register pair and an ID register.
module i2c_temp_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter logic [7:0] ID_VALUE = 8'hCB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic        busy,
    output logic        rd_byte_done,
    output logic [7:0]  ptr
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic [15:0] shadow_q, shadow_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;
    logic        load_tx;
    logic [7:0]  rd_byte;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        shadow_d  = shadow_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rd_done_d = 1'b0;
        load_tx   = 1'b0;
        rd_byte   = reg_read(ptr_q, shadow_q, ID_VALUE);

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (shift_q[6:0] == DEV_ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = sda_s;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                // sda_oe doubles as the "ACK already driven" marker in both ACK states.
                S_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                        if (rw_q) shadow_d = temp_value;
                    end else if (rw_q) begin
                        state_d = S_RD_DATA;
                        load_tx = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        state_d   = S_WR_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        ptr_d   = {shift_q[6:0], sda_s};
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        state_d   = S_WR_DATA;
                        bit_cnt_d = '0;
                    end
                end
                // bit_cnt counts bits already put on the bus; 0 means load the next byte.
                S_RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        load_tx = 1'b1;
                    end else if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        rd_done_d = 1'b1;
                        ptr_d     = ptr_q + 8'd1;
                        state_d   = S_RD_ACK;
                    end else begin
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_RD_ACK: if (scl_rise) begin
                    if (!sda_s) begin
                        state_d   = S_RD_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (load_tx) begin
                sda_oe_d  = ~rd_byte[7];
                shift_d   = {rd_byte[6:0], 1'b0};
                bit_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            shadow_q  <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            shadow_q  <= shadow_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rd_done_q <= rd_done_d;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign rd_byte_done = rd_done_q;
    assign ptr          = ptr_q;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bus-level master driving i2c_temp_target against a transaction-level register model.
module tb_i2c_temp_target;

    localparam logic [6:0] DEV = 7'h4B;
    localparam int unsigned H  = 5;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] temp_value = 16'h0000;
    logic        sda_oe, busy, rd_byte_done;
    logic [7:0]  ptr;
    logic        sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_temp_target #(.DEV_ADDR(7'h4B), .ID_VALUE(8'hCB)) dut (
        .clk          (clk),
        .reset        (reset),
        .scl_in       (scl_m),
        .sda_in       (sda_bus),
        .sda_oe       (sda_oe),
        .temp_value   (temp_value),
        .busy         (busy),
        .rd_byte_done (rd_byte_done),
        .ptr          (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } cmp_t;

    cmp_t cq[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    logic bit_chk_en = 1'b0;
    logic bit_exp_oe = 1'b0;

    // Single compare process: per-cycle SDA drive check plus queued transaction checks.
    always @(negedge clk) begin : compare
        cmp_t c;
        if (bit_chk_en && scl_m) begin
            checks++;
            if (sda_oe !== bit_exp_oe) begin
                errors++;
                $display("FAIL sda_oe_bit actual=%0b required=%0b t=%0t", sda_oe, bit_exp_oe, $time);
            end
        end
        while (cq.size() > 0) begin
            c = cq.pop_front();
            checks++;
            if (c.act !== c.exp) begin
                errors++;
                $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", c.name, c.act, c.exp, $time);
            end
        end
    end

    always @(negedge clk) if (rd_byte_done === 1'b1) pulse_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    logic [7:0]  m_ptr = 8'h00;
    logic [15:0] m_shadow = 16'h0000;
    int          m_pulses = 0;
    logic        cur_match;
    logic [7:0]  rd_got [8];
    logic        chg_en = 1'b0;
    logic [15:0] chg_val = 16'h0000;

    function automatic logic [7:0] m_reg(input logic [7:0] p);
        if (p == 8'h00) return m_shadow[15:8];
        if (p == 8'h01) return m_shadow[7:0];
        if (p == 8'h0B) return 8'hCB;
        return 8'h00;
    endfunction

    task automatic expect_eq(input string n, input logic [31:0] a, input logic [31:0] e);
        cq.push_back('{n, a, e});
    endtask

    // ---------------- bus master ----------------
    task automatic qwait();
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic do_bit(input logic b, input logic exp_oe, output logic r);
        qwait();
        sda_m = b;
        qwait();
        scl_m = 1'b1;
        bit_exp_oe = exp_oe;
        bit_chk_en = 1'b1;
        qwait();
        r = sda_bus;
        qwait();
        bit_chk_en = 1'b0;
        scl_m = 1'b0;
    endtask

    task automatic gen_start();
        if (!scl_m) begin
            qwait(); sda_m = 1'b1;
            qwait(); scl_m = 1'b1;
        end
        qwait(); sda_m = 1'b0;
        qwait(); scl_m = 1'b0;
    endtask

    task automatic gen_stop();
        qwait(); sda_m = 1'b0;
        qwait(); scl_m = 1'b1;
        qwait(); sda_m = 1'b1;
        qwait();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack);
        logic r;
        for (int i = 7; i >= 0; i--) do_bit(d[i], 1'b0, r);
        do_bit(1'b1, exp_ack, r);
        expect_eq("ack_seen", {31'b0, r}, {31'b0, ~exp_ack});
    endtask

    task automatic recv_byte(input logic [7:0] e, input logic mack, output logic [7:0] g);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            do_bit(1'b1, ~e[i], r);
            g[i] = r;
        end
        do_bit(~mack, 1'b0, r);
        expect_eq("rd_byte", {24'b0, g}, {24'b0, e});
    endtask

    task automatic do_read(input logic [6:0] addr, input int unsigned n);
        logic [7:0] e, g;
        cur_match = (addr == DEV);
        gen_start();
        send_byte({addr, 1'b1}, cur_match);
        expect_eq("busy_after_addr", {31'b0, busy}, {31'b0, cur_match});
        if (cur_match) m_shadow = temp_value;
        for (int unsigned i = 0; i < n; i++) begin
            e = cur_match ? m_reg(m_ptr) : 8'hFF;
            recv_byte(e, (i + 1 < n), g);
            rd_got[i] = g;
            if (cur_match) begin
                m_ptr = m_ptr + 8'd1;
                m_pulses++;
            end
            if (chg_en && i == 0) temp_value = chg_val;
        end
    endtask

    task automatic do_write(input logic [6:0] addr);
        cur_match = (addr == DEV);
        gen_start();
        send_byte({addr, 1'b0}, cur_match);
        expect_eq("busy_after_waddr", {31'b0, busy}, {31'b0, cur_match});
    endtask

    task automatic wr_byte(input logic [7:0] d);
        send_byte(d, cur_match);
        if (cur_match) m_ptr = d;
    endtask

    task automatic end_txn();
        gen_stop();
        expect_eq("busy_after_stop", {31'b0, busy}, 32'd0);
        expect_eq("sda_oe_after_stop", {31'b0, sda_oe}, 32'd0);
        expect_eq("ptr", {24'b0, ptr}, {24'b0, m_ptr});
        expect_eq("rd_pulses", pulse_cnt, m_pulses);
    endtask

    function automatic logic [7:0] pick_ptr();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h0B;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- sequence ----------------
    initial begin
        int         base;
        logic [7:0] b;
        logic [6:0] a;
        logic       r;

        repeat (4) @(posedge clk);
        #1;
        expect_eq("reset_sda_oe", {31'b0, sda_oe}, 32'd0);
        expect_eq("reset_busy", {31'b0, busy}, 32'd0);
        expect_eq("reset_rd_done", {31'b0, rd_byte_done}, 32'd0);
        expect_eq("reset_ptr", {24'b0, ptr}, 32'h00);
        reset = 1'b0;
        qwait();

        // Two-byte temperature read, NACK on the second byte.
        temp_value = 16'h0C80;
        base = pulse_cnt;
        do_read(DEV, 2);
        end_txn();
        expect_eq("lit_msb", {24'b0, rd_got[0]}, 32'h0C);
        expect_eq("lit_lsb", {24'b0, rd_got[1]}, 32'h80);
        expect_eq("lit_ptr_02", {24'b0, ptr}, 32'h02);
        expect_eq("lit_pulses_2", pulse_cnt - base, 32'd2);

        // Foreign address: never driven, never busy.
        do_read(7'h48, 2);
        end_txn();

        // Write pointer 0x0B then repeated START read of the ID.
        do_write(DEV);
        wr_byte(8'h0B);
        do_read(DEV, 1);
        end_txn();
        expect_eq("lit_id", {24'b0, rd_got[0]}, 32'hCB);

        // Temperature changes between MSB and LSB of one read.
        temp_value = 16'h0C80;
        do_write(DEV);
        wr_byte(8'h00);
        chg_en = 1'b1;
        chg_val = 16'h0D00;
        do_read(DEV, 2);
        chg_en = 1'b0;
        end_txn();
        expect_eq("lit_tear_msb", {24'b0, rd_got[0]}, 32'h0C);
        expect_eq("lit_tear_lsb", {24'b0, rd_got[1]}, 32'h80);
        do_write(DEV);
        wr_byte(8'h00);
        do_read(DEV, 2);
        end_txn();
        expect_eq("lit_new_msb", {24'b0, rd_got[0]}, 32'h0D);
        expect_eq("lit_new_lsb", {24'b0, rd_got[1]}, 32'h00);

        // STOP after four bits of a read byte (0x0C: next bit is a 1, bus free).
        temp_value = 16'h0C80;
        do_write(DEV);
        wr_byte(8'h00);
        do_read(DEV, 0);
        b = 8'h0C;
        for (int i = 7; i >= 4; i--) do_bit(1'b1, ~b[i], r);
        qwait(); sda_m = 1'b0;
        qwait(); scl_m = 1'b1;
        qwait(); sda_m = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("abort_sda_oe", {31'b0, sda_oe}, 32'd0);
        expect_eq("abort_busy", {31'b0, busy}, 32'd0);
        expect_eq("abort_ptr", {24'b0, ptr}, 32'h00);
        qwait();
        do_read(DEV, 1);
        end_txn();
        expect_eq("lit_after_abort", {24'b0, rd_got[0]}, 32'h0C);

        // Pointer wrap 0xFF -> 0x00.
        do_write(DEV);
        wr_byte(8'hFF);
        end_txn();
        do_read(DEV, 2);
        end_txn();
        expect_eq("lit_wrap_b0", {24'b0, rd_got[0]}, 32'h00);
        expect_eq("lit_wrap_b1", {24'b0, rd_got[1]}, 32'h0C);
        expect_eq("lit_wrap_ptr", {24'b0, ptr}, 32'h01);

        // Randomized transactions against the model.
        for (int t = 0; t < 30; t++) begin
            temp_value = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    do_write(DEV);
                    wr_byte(pick_ptr());
                    if ($urandom_range(0, 1) == 1) do_read(DEV, $urandom_range(1, 3));
                end
                1: do_read(DEV, $urandom_range(1, 4));
                2: begin
                    a = 7'($urandom);
                    if (a == DEV) a = a ^ 7'h01;
                    do_read(a, $urandom_range(1, 2));
                end
                default: begin
                    a = 7'($urandom);
                    if (a == DEV) a = a ^ 7'h10;
                    do_write(a);
                    wr_byte(8'($urandom));
                end
            endcase
            end_txn();
        end

        // Reset while the target is pulling SDA low must release it without a clock.
        reset = 1'b1;
        qwait();
        reset = 1'b0;
        m_ptr = 8'h00;
        m_shadow = 16'h0000;
        temp_value = 16'h0000;
        qwait();
        cur_match = 1'b1;
        gen_start();
        send_byte({DEV, 1'b1}, 1'b1);
        qwait(); sda_m = 1'b1;
        qwait(); scl_m = 1'b1;
        qwait();
        expect_eq("pre_reset_drive", {31'b0, sda_oe}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        expect_eq("async_reset_release", {31'b0, sda_oe}, 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        qwait();
        reset = 1'b0;
        qwait();
        expect_eq("post_reset_ptr", {24'b0, ptr}, 32'h00);

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_temp_target.md
I2C_TEMP_TARGET -- requirements
Module: i2c_temp_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h4B, 7-bit target address matched on bus.
REQ-002 SHALL have parameter ID_VALUE, default 8'hCB, value returned from register 0x0B.
REQ-003 SHALL have port clk input 1, system clock; reset input 1, reset, asynchronous, active-high.
REQ-004 SHALL have port scl_in input 1, raw bus SCL (asynchronous to clk).
REQ-005 SHALL have port sda_in input 1, raw bus SDA (asynchronous to clk).
REQ-006 SHALL have port sda_oe output 1, 1 = pull SDA low (open-drain), 0 = release.
REQ-007 SHALL have port temp_value input 16, current temperature {MSB,LSB}.
REQ-008 SHALL have port busy output 1, high from address match until STOP or START.
REQ-009 SHALL have port rd_byte_done output 1, one-cycle pulse per transmitted data byte.
REQ-010 SHALL have port ptr output 8, current register pointer.

Function
REQ-011 SHALL pass scl_in/sda_in through 2-FF synchronizers plus one history FF; all edge and condition detection uses synchronized signals.
REQ-012 SHALL detect START as SDA 1->0 while SCL high and STOP as SDA 0->1 while SCL high.
REQ-013 SHALL implement states S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK.
REQ-014 SHALL enter S_ADDR with bit count 0 on START from any state, including repeated START mid-byte.
REQ-015 SHALL enter S_IDLE and set sda_oe=0, busy=0 on STOP from any state.
REQ-016 SHALL sample SDA on SCL rising edge, MSB first, and change sda_oe only on SCL falling edge.
REQ-017 In S_ADDR, after 8 bits: if addr[7:1]==DEV_ADDR, go to S_ADDR_ACK, assert sda_oe at the next SCL falling edge, and set busy; otherwise go to S_IDLE, never drive.
REQ-018 On match with R/W=1, SHALL snapshot temp_value into a 16-bit shadow at the ACK bit; all bytes of that transaction come from the shadow (no tearing).
REQ-019 SHALL provide read data: ptr 0x00 -> shadow[15:8]; 0x01 -> shadow[7:0]; 0x0B -> ID_VALUE; any other -> 8'h00.
REQ-020 After address ACK with R/W=1, SHALL go to S_RD_DATA and drive each bit as sda_oe = ~bit, changing on SCL falling edges.
REQ-021 After 8 read bits, SHALL release SDA, pulse rd_byte_done, increment ptr (8-bit wrap 0xFF->0x00), and go to S_RD_ACK.
REQ-022 In S_RD_ACK, SHALL sample the master bit on SCL rising edge: 0 (ACK) -> S_RD_DATA with next byte; 1 (NACK) -> S_IDLE (SDA released).
REQ-023 After address ACK with R/W=0, SHALL go to S_WR_DATA; each received byte loads ptr, then S_WR_ACK drives ACK for one SCL period and returns to S_WR_DATA.
REQ-024 SHALL release sda_oe at the SCL falling edge ending every ACK bit it drives.
REQ-025 SHALL operate correctly for clk >= 16x SCL frequency; detection latency is 3 clk after a raw bus edge.
REQ-026 SHALL ignore SCL edges in S_IDLE.
REQ-027 ptr SHALL persist across transactions (cleared only by reset).

Reset
REQ-028 On reset, SHALL set state=S_IDLE, sda_oe=0, busy=0, rd_byte_done=0, ptr=8'h00, shadow=16'h0000, and synchronizers to 1 (bus idle).
REQ-029 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously).

Structure
REQ-030 SHALL place state enum and register constants (REG_TEMP_MSB=8'h00, REG_TEMP_LSB=8'h01, REG_ID=8'h0B) in a shared package i2c_pkg.
REQ-031 SHALL use one sub-module i2c_bus_sync (synchronizers, SCL edge detectors, START/STOP detection); the rest stays in one FSM.

Verification
REQ-032 Read 0x4B, temp_value=16'h0C80, master ACKs byte 1 and NACKs byte 2 -> bytes 0x0C, 0x80 received; two rd_byte_done pulses; ptr=0x02; SDA released after NACK.
REQ-033 Address 0x48 read -> sda_oe stays 0 for whole transaction; busy stays 0.
REQ-034 Write 0x4B, byte 0x0B, repeated START, read one byte with NACK -> ACKs on both write bytes; read returns 0xCB.
REQ-035 temp_value changes 16'h0C80->16'h0D00 between MSB and LSB of one read -> returns 0x0C, 0x80; next transaction returns 0x0D, 0x00.
REQ-036 STOP injected after bit 3 of a read byte -> sda_oe=0 within 3 clk, state S_IDLE; next read still works.
REQ-037 Write ptr=0xFF, read two bytes with ACK then NACK -> 0x00 then 0x0C (temp_value=16'h0C80); ptr ends at 0x01.
